instruction_fetch: RTL and testbench

Fetch stage of the RISC-V softcore and the initiator on the instruction memory's byte-addressed, combinational-read port. Holds the program counter and drives the fetch address. Registers each returned little-endian word, with its PC, into a one-entry output stage toward decode, using a valid/ready handshake. Also handles branch/jump redirects and flags misaligned or out-of-range fetches.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_fault_check.sv | 22 ++
 rtl/instruction_fetch.sv | 108 ++++++++++
 tb/tb_instruction_fetch.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V softcore: fetch FSM states, the canonical
// NOP encoding and default memory-map parameters.
package riscv_pkg;

  localparam logic [31:0] NOP                = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int unsigned DEFAULT_IMEM_BYTES = 32'd1024;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fault_check.sv
// Combinational word-access legality check: flags misaligned addresses and
// addresses whose word would extend past the end of a memory of MEM_BYTES.
module fetch_fault_check
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEFAULT_IMEM_BYTES
) (
  input  logic [31:0] addr_i,
  output logic        fault_o
);

  // 33-bit compare so addresses near 2^32 cannot wrap into the legal range.
  localparam logic [32:0] LAST_WORD = 33'(MEM_BYTES) - 33'd4;

  logic misaligned_s;
  logic out_of_range_s;

  assign misaligned_s   = (addr_i[1:0] != 2'b00);
  assign out_of_range_s = ({1'b0, addr_i} > LAST_WORD);
  assign fault_o        = misaligned_s | out_of_range_s;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and holds
// one fetched entry toward decode behind a valid/ready handshake.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_BYTES = DEFAULT_IMEM_BYTES
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic [31:0] imem_address_o,
  input  logic [31:0] imem_instruction_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_instruction_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_fault_o,
  output logic [31:0] fetch_count_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  entry_pc_q, entry_pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  count_q, count_d;

  logic [31:0]  addr_s;
  logic         addr_fault_s;
  logic         load_s;
  logic         accept_s;

  assign addr_s   = redirect_valid_i ? redirect_pc_i : pc_q;
  assign accept_s = valid_q & fetch_ready_i;
  assign load_s   = redirect_valid_i |
                    ((state_q == RUN) & (~valid_q | fetch_ready_i));

  fetch_fault_check #(
    .MEM_BYTES (IMEM_BYTES)
  ) u_fault_check (
    .addr_i  (addr_s),
    .fault_o (addr_fault_s)
  );

  // Next-state logic for PC, output stage, FSM and handshake counter.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    entry_pc_d = entry_pc_q;
    fault_d    = fault_q;
    count_d    = count_q + {31'd0, accept_s};

    if (load_s) begin
      valid_d    = 1'b1;
      entry_pc_d = addr_s;
      if (addr_fault_s) begin
        // PC parks on the bad address so it stays visible on imem_address_o.
        instr_d = NOP;
        fault_d = 1'b1;
        pc_d    = addr_s;
        state_d = FAULT;
      end else begin
        instr_d = imem_instruction_i;
        fault_d = 1'b0;
        pc_d    = addr_s + 32'd4;
        state_d = RUN;
      end
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0000_0000;
      entry_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
      count_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      entry_pc_q <= entry_pc_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign imem_address_o      = addr_s;
  assign fetch_valid_o       = valid_q;
  assign fetch_instruction_o = instr_q;
  assign fetch_pc_o          = entry_pc_q;
  assign fetch_fault_o       = fault_q;
  assign fetch_count_o       = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, stall, redirect,
// fault entries, end-of-memory boundary and asynchronous reset mid-stream.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instruction;
  logic [31:0] fetch_pc;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [7:0]  mem [0:1023];
  int          checks;
  int          errors;

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (1024)
  ) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .imem_address_o      (imem_address),
    .imem_instruction_i  (imem_instruction),
    .redirect_valid_i    (redirect_valid),
    .redirect_pc_i       (redirect_pc),
    .fetch_valid_o       (fetch_valid),
    .fetch_ready_i       (fetch_ready),
    .fetch_instruction_o (fetch_instruction),
    .fetch_pc_o          (fetch_pc),
    .fetch_fault_o       (fetch_fault),
    .fetch_count_o       (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian combinational instruction memory model.
  always_comb begin
    if (imem_address <= 32'd1020) begin
      imem_instruction = {mem[imem_address[9:0] + 10'd3], mem[imem_address[9:0] + 10'd2],
                          mem[imem_address[9:0] + 10'd1], mem[imem_address[9:0]]};
    end else begin
      imem_instruction = 32'hBAD0_BAD0;
    end
  end

  task automatic put_word(input int addr, input logic [31:0] w);
    mem[addr]     = w[7:0];
    mem[addr + 1] = w[15:8];
    mem[addr + 2] = w[23:16];
    mem[addr + 3] = w[31:24];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic entry(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic f, input logic [31:0] cnt);
    chk({tag, "_valid"}, {31'd0, fetch_valid}, {31'd0, v});
    chk({tag, "_pc"},    fetch_pc, pc);
    chk({tag, "_instr"}, fetch_instruction, ins);
    chk({tag, "_fault"}, {31'd0, fetch_fault}, {31'd0, f});
    chk({tag, "_count"}, fetch_count, cnt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int a = 0; a < 1024; a += 4) put_word(a, {16'hA5A5, 16'(a)});
    put_word(0,    32'h0040_2103);
    put_word(20,   32'h0420_2023);
    put_word(1020, 32'hDEAD_BEEF);

    rst_n          = 1'b0;
    fetch_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    #1;
    entry("reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'd0);
    chk("reset_addr", imem_address, 32'h0);

    #11;
    rst_n       = 1'b1;
    fetch_ready = 1'b1;
    step();
    entry("first", 1'b1, 32'd0, 32'h0040_2103, 1'b0, 32'd0);
    chk("first_addr", imem_address, 32'd4);
    step();
    entry("seq4", 1'b1, 32'd4, 32'hA5A5_0004, 1'b0, 32'd1);
    step();
    entry("seq8", 1'b1, 32'd8, 32'hA5A5_0008, 1'b0, 32'd2);

    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      entry("stall", 1'b1, 32'd8, 32'hA5A5_0008, 1'b0, 32'd2);
      chk("stall_addr", imem_address, 32'd12);
    end
    fetch_ready = 1'b1;
    step();
    entry("release", 1'b1, 32'd12, 32'hA5A5_000C, 1'b0, 32'd3);

    fetch_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd4;
    step();
    entry("redir4", 1'b1, 32'd4, 32'hA5A5_0004, 1'b0, 32'd3);
    redirect_pc = 32'h14;
    step();
    entry("redir14", 1'b1, 32'h14, 32'h0420_2023, 1'b0, 32'd3);

    redirect_pc = 32'd6;
    step();
    redirect_valid = 1'b0;
    #1;
    entry("misalign", 1'b1, 32'd6, 32'h0000_0013, 1'b1, 32'd3);
    chk("misalign_addr", imem_address, 32'd6);
    step();
    entry("fault_hold", 1'b1, 32'd6, 32'h0000_0013, 1'b1, 32'd3);
    fetch_ready = 1'b1;
    step();
    chk("fault_acc_valid", {31'd0, fetch_valid}, 32'd0);
    chk("fault_acc_count", fetch_count, 32'd4);
    step();
    chk("fault_idle_valid", {31'd0, fetch_valid}, 32'd0);
    chk("fault_idle_count", fetch_count, 32'd4);
    chk("fault_idle_addr", imem_address, 32'd6);

    redirect_valid = 1'b1;
    redirect_pc    = 32'd0;
    step();
    redirect_valid = 1'b0;
    entry("resume0", 1'b1, 32'd0, 32'h0040_2103, 1'b0, 32'd4);
    step();
    entry("resume4", 1'b1, 32'd4, 32'hA5A5_0004, 1'b0, 32'd5);

    redirect_valid = 1'b1;
    redirect_pc    = 32'd1016;
    step();
    redirect_valid = 1'b0;
    entry("b1016", 1'b1, 32'd1016, 32'hA5A5_03F8, 1'b0, 32'd6);
    step();
    entry("b1020", 1'b1, 32'd1020, 32'hDEAD_BEEF, 1'b0, 32'd7);
    step();
    entry("b1024", 1'b1, 32'd1024, 32'h0000_0013, 1'b1, 32'd8);
    chk("b1024_addr", imem_address, 32'd1024);
    step();
    chk("b1024_acc_valid", {31'd0, fetch_valid}, 32'd0);
    chk("b1024_acc_count", fetch_count, 32'd9);

    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    fetch_ready    = 1'b0;
    step();
    redirect_valid = 1'b0;
    #1;
    entry("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0000_0013, 1'b1, 32'd9);
    chk("wrap_addr", imem_address, 32'hFFFF_FFFC);

    redirect_valid = 1'b1;
    redirect_pc    = 32'd0;
    step();
    redirect_valid = 1'b0;
    entry("pre_rst", 1'b1, 32'd0, 32'h0040_2103, 1'b0, 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    entry("mid_rst", 1'b0, 32'd0, 32'h0, 1'b0, 32'd0);
    chk("mid_rst_addr", imem_address, 32'd0);
    #10;
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
